// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: tracks in-flight destinations through
// EX/DM/WB and produces registered operand selects for the register bank.
module fwd_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter bit ZERO_FWD = 1'b0,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_ra,
    input  logic [REG_AW-1:0]   id_rb,
    input  logic [REG_AW-1:0]   id_rw,
    input  logic                id_we,
    input  logic                id_load,
    input  logic                id_imm,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          mux_sel_A,
    output logic [1:0]          mux_sel_B,
    output logic                imm_sel,
    output logic [STALL_CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        SEL_REG = 2'b00,
        SEL_EX  = 2'b01,
        SEL_DM  = 2'b10,
        SEL_WB  = 2'b11
    } sel_e;

    typedef struct packed {
        logic [REG_AW-1:0] rw;
        logic              we;
        logic              load;
    } tag_t;

    // t1 heads for EX next cycle, t2 for DM, t3 for WB.
    tag_t t1, t2, t3;
    tag_t new_tag;
    logic issue;
    logic load_use;
    sel_e sel_a, sel_b;

    // Newest matching stage wins; the issuing instruction's own rw is never compared.
    function automatic sel_e fwd_sel(input logic [REG_AW-1:0] src,
                                     input tag_t s1, input tag_t s2, input tag_t s3);
        sel_e res;
        res = SEL_REG;
        if (ZERO_FWD && src == '0)
            res = SEL_REG;
        else if (s1.we && s1.rw == src)
            res = SEL_EX;
        else if (s2.we && s2.rw == src)
            res = SEL_DM;
        else if (s3.we && s3.rw == src)
            res = SEL_WB;
        return res;
    endfunction

    always_comb begin
        load_use = t1.we && t1.load &&
                   ((t1.rw == id_ra) || ((t1.rw == id_rb) && !id_imm));
        stall    = !rst && id_valid && !flush && load_use;
        issue    = !rst && id_valid && !flush && !stall;
        sel_a    = fwd_sel(id_ra, t1, t2, t3);
        sel_b    = fwd_sel(id_rb, t1, t2, t3);
        new_tag  = '0;
        if (issue) begin
            new_tag.rw   = id_rw;
            new_tag.we   = id_we;
            new_tag.load = id_load;
        end
    end

    // NOTE: all state below uses non-blocking assignments so the three-stage
    // shift reads the pre-edge values of every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            t1        <= '0;
            t2        <= '0;
            t3        <= '0;
            mux_sel_A <= SEL_REG;
            mux_sel_B <= SEL_REG;
            imm_sel   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            t3 <= t2;
            t2 <= t1;
            t1 <= new_tag;
            if (issue) begin
                mux_sel_A <= sel_a;
                mux_sel_B <= sel_b;
                imm_sel   <= id_imm;
            end else begin
                mux_sel_A <= SEL_REG;
                mux_sel_B <= SEL_REG;
                imm_sel   <= 1'b0;
            end
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized bench for fwd_hazard_ctrl: two instances (default, and r0-blocking with a
// narrow stall counter) checked against an age-ordered history model.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, id_valid, id_we, id_load, id_imm, flush;
    logic [4:0] id_ra, id_rb, id_rw;

    logic        stall0, imm_sel0;
    logic [1:0]  sel_a0, sel_b0;
    logic [15:0] cnt0;
    logic        stall1, imm_sel1;
    logic [1:0]  sel_a1, sel_b1;
    logic [2:0]  cnt1;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5), .ZERO_FWD(1'b0), .STALL_CW(16)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_rw(id_rw), .id_we(id_we), .id_load(id_load), .id_imm(id_imm), .flush(flush),
        .stall(stall0), .mux_sel_A(sel_a0), .mux_sel_B(sel_b0), .imm_sel(imm_sel0),
        .stall_cnt(cnt0)
    );

    fwd_hazard_ctrl #(.REG_AW(5), .ZERO_FWD(1'b1), .STALL_CW(3)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_rw(id_rw), .id_we(id_we), .id_load(id_load), .id_imm(id_imm), .flush(flush),
        .stall(stall1), .mux_sel_A(sel_a1), .mux_sel_B(sel_b1), .imm_sel(imm_sel1),
        .stall_cnt(cnt1)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_vec++;
        if (obs !== expd) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expd, $time);
        end
    endtask

    // Model: hist[k] is the instruction issued k+1 cycles ago (bubbles have we=0).
    typedef struct {
        logic [4:0] rw;
        bit         we;
        bit         load;
    } mtag_t;

    mtag_t hist[3];
    int    m_sel_a0, m_sel_b0, m_sel_a1, m_sel_b1, m_imm, m_cnt0, m_cnt1;

    function automatic int model_sel(input logic [4:0] src, input bit zf);
        if (zf && src == 0) return 0;
        for (int age = 0; age < 3; age++)
            if (hist[age].we && hist[age].rw == src) return age + 1;
        return 0;
    endfunction

    task automatic step(input bit r, input bit v, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rw, input bit we, input bit ld, input bit im,
                        input bit fl);
        bit exp_stall, issue;
        @(negedge clk);
        rst = r; id_valid = v; id_ra = ra; id_rb = rb; id_rw = rw;
        id_we = we; id_load = ld; id_imm = im; flush = fl;
        #1;
        exp_stall = !r && v && !fl && hist[0].we && hist[0].load &&
                    (hist[0].rw == ra || (hist[0].rw == rb && !im));
        issue = !r && v && !fl && !exp_stall;
        check("stall0", stall0, exp_stall);
        check("stall1", stall1, exp_stall);
        if (r) begin
            for (int k = 0; k < 3; k++) hist[k] = '{5'd0, 1'b0, 1'b0};
            m_sel_a0 = 0; m_sel_b0 = 0; m_sel_a1 = 0; m_sel_b1 = 0;
            m_imm = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            m_sel_a0 = issue ? model_sel(ra, 1'b0) : 0;
            m_sel_b0 = issue ? model_sel(rb, 1'b0) : 0;
            m_sel_a1 = issue ? model_sel(ra, 1'b1) : 0;
            m_sel_b1 = issue ? model_sel(rb, 1'b1) : 0;
            m_imm    = (issue && im) ? 1 : 0;
            if (exp_stall) begin
                m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : 65535;
                m_cnt1 = (m_cnt1 < 7) ? m_cnt1 + 1 : 7;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = issue ? '{rw, we, ld} : '{5'd0, 1'b0, 1'b0};
        end
        @(posedge clk);
        #1;
        check("sel_a0", sel_a0, m_sel_a0);
        check("sel_b0", sel_b0, m_sel_b0);
        check("imm0",   imm_sel0, m_imm);
        check("cnt0",   cnt0, m_cnt0);
        check("sel_a1", sel_a1, m_sel_a1);
        check("sel_b1", sel_b1, m_sel_b1);
        check("imm1",   imm_sel1, m_imm);
        check("cnt1",   cnt1, m_cnt1);
    endtask

    task automatic bubble();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; id_valid = 0; id_ra = 0; id_rb = 0; id_rw = 0;
        id_we = 0; id_load = 0; id_imm = 0; flush = 0;
        for (int k = 0; k < 3; k++) hist[k] = '{5'd0, 1'b0, 1'b0};

        // reset with live inputs, then idle
        step(1, 1, 1, 1, 1, 1, 1, 0, 0);
        bubble();
        check("idle_sel_a", sel_a0, 0);
        check("idle_cnt", cnt0, 0);

        // back-to-back writer r3, reader r3,r4
        step(0, 1, 1, 2, 3, 1, 0, 0, 0);
        step(0, 1, 3, 4, 6, 1, 0, 0, 0);
        check("b2b_sel_a", sel_a0, 2'b01);
        check("b2b_sel_b", sel_b0, 2'b00);

        // writer r5, two bubbles -> WB; three bubbles -> register
        step(0, 1, 0, 0, 5, 1, 0, 0, 0); bubble(); bubble();
        step(0, 1, 5, 5, 0, 0, 0, 0, 0);
        check("wb_sel_a", sel_a0, 2'b11);
        step(0, 1, 0, 0, 5, 1, 0, 0, 0); bubble(); bubble(); bubble();
        step(0, 1, 5, 5, 0, 0, 0, 0, 0);
        check("old_sel_a", sel_a0, 2'b00);

        // two writers of r7, newest wins
        step(0, 1, 0, 0, 7, 1, 0, 0, 0);
        step(0, 1, 0, 0, 7, 1, 0, 0, 0);
        step(0, 1, 7, 0, 8, 1, 0, 1, 0);
        check("newest_sel_a", sel_a0, 2'b01);
        check("newest_imm", imm_sel0, 1);

        // self-forwarding never happens
        bubble(); bubble(); bubble();
        step(0, 1, 9, 9, 9, 1, 0, 0, 0);
        check("self_sel_a", sel_a0, 2'b00);

        // load-use: stall once, then DM select
        step(0, 1, 0, 0, 2, 1, 1, 0, 0);
        step(0, 1, 2, 4, 10, 1, 0, 0, 0);
        check("lu_stall_cnt", cnt0, 1);
        step(0, 1, 2, 4, 10, 1, 0, 0, 0);
        check("lu_sel_a", sel_a0, 2'b10);

        // load-use with flush: no stall, counter unchanged
        step(0, 1, 0, 0, 2, 1, 1, 0, 0);
        step(0, 1, 2, 0, 0, 0, 0, 0, 1);
        check("flush_cnt", cnt0, 1);

        // r0 forwarding blocked only in the ZERO_FWD instance
        bubble(); bubble(); bubble();
        step(0, 1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0);
        check("r0_fwd_on", sel_a0, 2'b01);
        check("r0_fwd_off", sel_a1, 2'b00);

        // reset mid-stall discards the pending load
        step(0, 1, 0, 0, 3, 1, 1, 0, 0);
        step(1, 1, 3, 3, 0, 0, 0, 0, 0);
        step(0, 1, 3, 3, 0, 0, 0, 0, 0);
        check("rst_mid_stall", sel_a0, 2'b00);

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            logic [4:0] ra, rb, rw;
            bit wide;
            wide = ($urandom_range(0, 7) == 0);
            ra = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            rb = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            rw = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, ra, rb, rw,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
